nano_boot_loader: RTL and testbench

Boot and run sequencer for the NanoCPU. Holds the CPU in reset, streams a program image into the shared 256x16 single-port memory, hands the memory bus to the CPU, and runs it for a bounded number of cycles before forcing it back into reset. It sits between the CPU memory port, the memory, and an external word-stream source such as a UART or testbench feeder.

---
 rtl/nano_boot_loader_if.sv | 32 +++
 rtl/nano_boot_loader.sv | 148 ++++++++++++++
 tb/tb_nano_boot_loader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nano_boot_loader_if.sv
// Bus bundle for nano_boot_loader: word-stream input, CPU memory port and
// shared-memory port.
//   slave  : the boot loader (consumes stream and CPU strobes, drives memory)
//   master : the environment (feeder, CPU, memory)
interface nano_boot_loader_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
);
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;

  logic [AW-1:0] cpu_address;
  logic [DW-1:0] cpu_dataW;
  logic          cpu_ce;
  logic          cpu_we;

  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_dataW;
  logic          mem_ce;
  logic          mem_we;

  modport slave (
    input  s_valid, s_data, cpu_address, cpu_dataW, cpu_ce, cpu_we,
    output s_ready, mem_address, mem_dataW, mem_ce, mem_we
  );

  modport master (
    output s_valid, s_data, cpu_address, cpu_dataW, cpu_ce, cpu_we,
    input  s_ready, mem_address, mem_dataW, mem_ce, mem_we
  );
endinterface

// File: rtl/nano_boot_loader.sv
// Boot and run sequencer for the NanoCPU. Holds the CPU in reset, streams an
// image into the shared memory, hands the memory bus to the CPU and runs it
// for a bounded number of cycles.
// Ports:
//   ck, rst          clock (rising edge), async active-high reset
//   start            pulse: begin load+run (accepted in IDLE/HALT)
//   len, run_limit   image length / run cycles (0 = unlimited), sampled on start
//   abort            stop the sequence (LOAD/RUN only)
//   bus              stream, CPU memory port and memory port (slave side)
//   cpu_rst          registered CPU reset
//   busy, done       LOAD|RUN, HALT
//   timeout          HALT reached through run_limit
//   cycles           CPU cycles run in the last or current RUN
module nano_boot_loader #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 16
) (
  input  logic                ck,
  input  logic                rst,
  input  logic                start,
  input  logic [AW:0]         len,
  input  logic [CW-1:0]       run_limit,
  input  logic                abort,
  nano_boot_loader_if.slave   bus,
  output logic                cpu_rst,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic [CW-1:0]       cycles
);

  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [LW-1:0] len_q;
  logic [CW-1:0] limit_q;
  logic [LW-1:0] wcnt;

  logic start_acc;
  logic word_acc;
  logic last_word;
  logic limit_hit;

  assign start_acc = ((state == ST_IDLE) || (state == ST_HALT)) && start;
  assign word_acc  = (state == ST_LOAD) && bus.s_valid;
  // Compare wcnt+1 against len so len=2^AW needs no wider arithmetic.
  assign last_word = word_acc && ((wcnt + LW'(1)) == len_q);
  assign limit_hit = (state == ST_RUN) && (limit_q != '0) &&
                     (cycles == (limit_q - CW'(1)));

  // State register
  always_ff @(posedge ck or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort outranks both last-word and limit expiry
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (start) state_nxt = (len == '0) ? ST_RUN : ST_LOAD;
      end
      ST_LOAD: begin
        if (abort)          state_nxt = ST_HALT;
        else if (last_word) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (abort)          state_nxt = ST_HALT;
        else if (limit_hit) state_nxt = ST_HALT;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode; the memory port is muxed combinationally so writes
  // land on the edge ending the accepting cycle
  always_comb begin
    bus.s_ready     = 1'b0;
    bus.mem_address = '0;
    bus.mem_dataW   = '0;
    bus.mem_ce      = 1'b0;
    bus.mem_we      = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    case (state)
      ST_LOAD: begin
        busy        = 1'b1;
        bus.s_ready = 1'b1;
        if (bus.s_valid) begin
          bus.mem_address = wcnt[AW-1:0];
          bus.mem_dataW   = bus.s_data;
          bus.mem_ce      = 1'b1;
          bus.mem_we      = 1'b1;
        end
      end
      ST_RUN: begin
        busy            = 1'b1;
        bus.mem_address = bus.cpu_address;
        bus.mem_dataW   = bus.cpu_dataW;
        bus.mem_ce      = bus.cpu_ce;
        bus.mem_we      = bus.cpu_we;
      end
      ST_HALT: done = 1'b1;
      default: ;
    endcase
  end

  // CPU reset flop: low exactly while the next state is RUN
  always_ff @(posedge ck or posedge rst) begin
    if (rst) cpu_rst <= 1'b1;
    else     cpu_rst <= (state_nxt != ST_RUN);
  end

  // Sequence datapath: captured parameters, word counter, cycle counter
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      len_q   <= '0;
      limit_q <= '0;
      wcnt    <= '0;
      cycles  <= '0;
      timeout <= 1'b0;
    end else begin
      if (start_acc) begin
        len_q   <= len;
        limit_q <= run_limit;
        wcnt    <= '0;
        cycles  <= '0;
        timeout <= 1'b0;
      end
      if (word_acc) wcnt <= wcnt + LW'(1);
      if (state == ST_RUN) begin
        // Saturate only matters in unlimited mode
        if ((limit_q != '0) || (cycles != '1)) cycles <= cycles + CW'(1);
        if (limit_hit && !abort) timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nano_boot_loader.sv
module tb_nano_boot_loader;

  logic        ck = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  len;
  logic [15:0] run_limit;
  logic        abort;
  logic        cpu_rst, busy, done, timeout;
  logic [15:0] cycles;

  int checks = 0;
  int errors = 0;

  nano_boot_loader_if #(.AW(8), .DW(16)) bus ();

  nano_boot_loader #(.AW(8), .DW(16), .CW(16)) dut (
    .ck(ck), .rst(rst), .start(start), .len(len), .run_limit(run_limit),
    .abort(abort), .bus(bus), .cpu_rst(cpu_rst), .busy(busy), .done(done),
    .timeout(timeout), .cycles(cycles)
  );

  always #5 ck = ~ck;

  // Memory model and write/reset observers
  logic [15:0] model [256];
  int cyc = 0;
  int wr_count = 0;
  int wr0_count = 0;
  int first_wr_cyc = 0;
  int last_wr_cyc = 0;
  int last_addr = 0;
  int rst_low = 0;

  always @(posedge ck) begin
    cyc = cyc + 1;
    if (!rst && bus.mem_ce && bus.mem_we) begin
      model[bus.mem_address] = bus.mem_dataW;
      if (wr_count == 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      last_addr = int'(bus.mem_address);
      if (bus.mem_address == 8'h00) wr0_count = wr0_count + 1;
      wr_count = wr_count + 1;
    end
    if (!cpu_rst) rst_low = rst_low + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max; i++) begin
      if (done) break;
      step();
    end
  endtask

  task automatic clear_logs();
    wr_count = 0;
    wr0_count = 0;
    rst_low = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; run_limit = '0; abort = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    bus.cpu_address = '0; bus.cpu_dataW = '0; bus.cpu_ce = 1'b0; bus.cpu_we = 1'b0;

    // Reset values
    repeat (3) step();
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (5) step();
    chk("idle_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("idle_busy_done", {busy, done, timeout}, 32'd0);
    chk("idle_mem_strobes", {bus.mem_ce, bus.mem_we}, 32'd0);
    chk("idle_no_writes", 32'(wr_count), 32'd0);
    chk("idle_cycles", 32'(cycles), 32'd0);

    // Load 3 words, run 10 cycles
    start = 1'b1; len = 9'd3; run_limit = 16'd10;
    step();
    start = 1'b0;
    clear_logs();
    chk("load_s_ready", 32'(bus.s_ready), 32'd1);
    chk("load_busy", 32'(busy), 32'd1);
    bus.s_valid = 1'b1; bus.s_data = 16'h1A00;
    #1;
    chk("load_w0_strobe", {bus.mem_ce, bus.mem_we, bus.mem_address}, {22'd0, 2'b11, 8'h00});
    step();
    bus.s_data = 16'h2B00;
    step();
    bus.s_data = 16'hE000;
    step();
    bus.s_valid = 1'b0;
    chk("load_wr_count", 32'(wr_count), 32'd3);
    chk("load_consecutive", 32'(last_wr_cyc - first_wr_cyc), 32'd2);
    chk("load_mem0", 32'(model[0]), 32'h1A00);
    chk("load_mem1", 32'(model[1]), 32'h2B00);
    chk("load_mem2", 32'(model[2]), 32'hE000);
    chk("run_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("run_s_ready", 32'(bus.s_ready), 32'd0);
    bus.cpu_address = 8'h55; bus.cpu_dataW = 16'hBEEF; bus.cpu_ce = 1'b1; bus.cpu_we = 1'b0;
    #1;
    chk("run_passthru", {bus.mem_address, bus.mem_dataW, bus.mem_ce, bus.mem_we},
        {6'd0, 8'h55, 16'hBEEF, 2'b10});
    bus.cpu_address = '0; bus.cpu_dataW = '0; bus.cpu_ce = 1'b0;
    wait_done(40);
    chk("timed_done", 32'(done), 32'd1);
    chk("timed_timeout", 32'(timeout), 32'd1);
    chk("timed_cycles", 32'(cycles), 32'd10);
    chk("timed_rst_low", 32'(rst_low), 32'd10);
    chk("timed_cpu_rst", {cpu_rst, busy}, 32'b10);

    // Stream gap between two words
    start = 1'b1; len = 9'd2; run_limit = 16'd3;
    step();
    start = 1'b0;
    clear_logs();
    bus.s_valid = 1'b1; bus.s_data = 16'h1111;
    step();
    bus.s_valid = 1'b0;
    repeat (4) step();
    chk("gap_in_load", {busy, bus.s_ready, cpu_rst}, 32'b111);
    chk("gap_no_strobe", 32'(bus.mem_ce), 32'd0);
    bus.s_valid = 1'b1; bus.s_data = 16'h2222;
    step();
    bus.s_valid = 1'b0;
    chk("gap_wr_count", 32'(wr_count), 32'd2);
    chk("gap_mem1", 32'(model[1]), 32'h2222);
    chk("gap_run", 32'(cpu_rst), 32'd0);
    wait_done(20);
    chk("gap_halt", {done, timeout}, 32'b11);
    chk("gap_cycles", 32'(cycles), 32'd3);

    // Full 256-word image
    start = 1'b1; len = 9'd256; run_limit = 16'd1;
    step();
    start = 1'b0;
    clear_logs();
    bus.s_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.s_data = 16'hA500 ^ 16'(i);
      step();
    end
    bus.s_valid = 1'b0;
    chk("full_wr_count", 32'(wr_count), 32'd256);
    chk("full_last_addr", 32'(last_addr), 32'hFF);
    chk("full_mem_ff", 32'(model[255]), 32'hA5FF);
    chk("full_mem_00", 32'(model[0]), 32'hA500);
    chk("full_addr0_once", 32'(wr0_count), 32'd1);
    chk("full_run", {cpu_rst, busy}, 32'b01);
    step();
    chk("full_halt", {done, timeout, cycles}, {14'd0, 2'b11, 16'd1});

    // Abort in unlimited RUN on the 5th cycle
    start = 1'b1; len = 9'd0; run_limit = 16'd0;
    clear_logs();
    step();
    start = 1'b0;
    chk("abort_run_direct", {cpu_rst, busy}, 32'b01);
    repeat (4) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_halt", {done, timeout, cpu_rst}, 32'b101);
    chk("abort_cycles", 32'(cycles), 32'd5);
    chk("abort_rst_low", 32'(rst_low), 32'd5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_ignored_halt", {done, busy}, 32'b10);

    // Abort coincides with run_limit expiry
    start = 1'b1; len = 9'd0; run_limit = 16'd5;
    step();
    start = 1'b0;
    repeat (4) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("prio_limit_halt", 32'(done), 32'd1);
    chk("prio_limit_timeout", 32'(timeout), 32'd0);
    chk("prio_limit_cycles", 32'(cycles), 32'd5);

    // Abort coincides with the last word: word written, then HALT
    start = 1'b1; len = 9'd2; run_limit = 16'd0;
    step();
    start = 1'b0;
    clear_logs();
    bus.s_valid = 1'b1; bus.s_data = 16'h7700;
    step();
    bus.s_data = 16'h7701; abort = 1'b1;
    step();
    bus.s_valid = 1'b0; abort = 1'b0;
    chk("prio_word_written", 32'(wr_count), 32'd2);
    chk("prio_word_mem1", 32'(model[1]), 32'h7701);
    chk("prio_word_halt", {done, timeout, cpu_rst}, 32'b101);
    chk("prio_word_no_run", 32'(rst_low), 32'd0);

    // Reset in the middle of LOAD
    start = 1'b1; len = 9'd4; run_limit = 16'd0;
    step();
    start = 1'b0;
    clear_logs();
    bus.s_valid = 1'b1; bus.s_data = 16'h3000;
    step();
    bus.s_data = 16'h3001;
    step();
    bus.s_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("midrst_idle", {bus.s_ready, busy, done}, 32'd0);
    step();
    rst = 1'b0;
    chk("midrst_partial", 32'(wr_count), 32'd2);
    chk("midrst_mem1", 32'(model[1]), 32'h3001);
    start = 1'b1; len = 9'd0; run_limit = 16'd2;
    step();
    start = 1'b0;
    chk("midrst_len0_run", {cpu_rst, busy, bus.s_ready}, 32'b010);
    wait_done(20);
    chk("midrst_len0_halt", {done, timeout, cycles}, {14'd0, 2'b11, 16'd2});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
